// File: rtl/db_pkg.sv
// Shared types and constants for the contact-bounce emulator.
package db_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GLITCH = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // One right-shift step of the 16-bit Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/db_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed would lock up, so it is
// replaced by the default seed.
module db_lfsr16
  import db_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED_EFF;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/db_bounce_gen.sv
// Contact-bounce emulator: turns a clean level change into 2N+1 edges with
// LFSR-chosen glitch widths, then holds the final level for a settle period.
module db_bounce_gen
  import db_pkg::*;
#(
  parameter int          MAX_BOUNCES   = 4,
  parameter int          MAX_GLITCH    = 8,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [15:0] SEED          = LFSR_DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic level_in,
  output logic bounce_out,
  output logic busy
);

  localparam int SEG_W = $clog2(MAX_GLITCH + 1);
  localparam int REM_W = (MAX_BOUNCES > 0) ? $clog2(2 * MAX_BOUNCES + 1) : 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [3:0]       N_CAP       = 4'(MAX_BOUNCES);
  localparam logic [3:0]       L_CAP       = 4'(MAX_GLITCH - 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  logic [15:0] lfsr;

  db_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  logic unused_lfsr;
  assign unused_lfsr = ^lfsr[15:8];

  state_t           state_q, state_d;
  logic             target_q, target_d;
  logic             bounce_q, bounce_d;
  logic             busy_q, busy_d;
  logic             settled_q, settled_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [SET_W-1:0] settle_q, settle_d;

  // Draws: bounce count N and glitch width minus one (seg_ctr counts L-1 .. 0).
  logic [3:0]       n_draw;
  logic [3:0]       l_raw;
  logic [SEG_W-1:0] l_load;
  logic [REM_W-1:0] rem_load;

  always_comb begin
    n_draw   = (lfsr[3:0] > N_CAP) ? N_CAP : lfsr[3:0];
    l_raw    = (lfsr[7:4] > L_CAP) ? L_CAP : lfsr[7:4];
    l_load   = SEG_W'(l_raw);
    rem_load = REM_W'({n_draw, 1'b0});
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    bounce_d  = bounce_q;
    busy_d    = busy_q;
    settled_d = settled_q;
    seg_d     = seg_q;
    rem_d     = rem_q;
    settle_d  = settle_q;

    if (!enable) begin
      state_d   = IDLE;
      bounce_d  = level_in;
      settled_d = level_in;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bounce_d = settled_q;
          busy_d   = 1'b0;
          if (level_in != settled_q) begin
            target_d = level_in;
            bounce_d = level_in;
            busy_d   = 1'b1;
            if (n_draw == 4'd0) begin
              state_d  = SETTLE;
              settle_d = SETTLE_LOAD;
            end else begin
              state_d = GLITCH;
              seg_d   = l_load;
              rem_d   = rem_load;
            end
          end
        end

        // rem_q counts segments still to finish, including the current one.
        GLITCH: begin
          if (seg_q == '0) begin
            bounce_d = ~bounce_q;
            if (rem_q == REM_W'(1)) begin
              state_d  = SETTLE;
              settle_d = SETTLE_LOAD;
              rem_d    = '0;
              bounce_d = target_q;
            end else begin
              rem_d = rem_q - REM_W'(1);
              seg_d = l_load;
            end
          end else begin
            seg_d = seg_q - SEG_W'(1);
          end
        end

        SETTLE: begin
          if (settle_q == '0) begin
            settled_d = target_q;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            settle_d = settle_q - SET_W'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      target_q  <= 1'b0;
      bounce_q  <= 1'b0;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
      seg_q     <= '0;
      rem_q     <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      bounce_q  <= bounce_d;
      busy_q    <= busy_d;
      settled_q <= settled_d;
      seg_q     <= seg_d;
      rem_q     <= rem_d;
      settle_q  <= settle_d;
    end
  end

  assign bounce_out = bounce_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_db_bounce_gen.sv
// Self-checking bench for db_bounce_gen: randomized transitions compared
// cycle-for-cycle against a waveform model built from the LFSR draw rules.
module tb_db_bounce_gen;

  localparam int MB = 4;
  localparam int MG = 8;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic en_a, lvl_a, out_a, busy_a;
  logic en_b, lvl_b, out_b, busy_b;
  logic en_z, lvl_z, out_z, busy_z, out_c, busy_c;

  int checks = 0;
  int errors = 0;
  logic cur_a, cur_z;

  always #5 clk = ~clk;

  db_bounce_gen #(.SEED(16'h1234)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .level_in(lvl_a),
    .bounce_out(out_a), .busy(busy_a));

  db_bounce_gen #(.MAX_BOUNCES(0), .SETTLE_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .level_in(lvl_b),
    .bounce_out(out_b), .busy(busy_b));

  db_bounce_gen #(.SEED(16'h0000)) dut_z (
    .clk(clk), .rst_n(rst_n), .enable(en_z), .level_in(lvl_z),
    .bounce_out(out_z), .busy(busy_z));

  db_bounce_gen #(.SEED(16'hACE1)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(en_z), .level_in(lvl_z),
    .bounce_out(out_c), .busy(busy_c));

  // Reference LFSR stream for each seeded instance.
  function automatic logic [15:0] step(input logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  function automatic int n_of(input logic [15:0] v, input int mb);
    int n;
    n = int'(v[3:0]);
    return (n > mb) ? mb : n;
  endfunction

  logic [15:0] mdl_a, mdl_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_a <= 16'h1234;
      mdl_z <= 16'hACE1;
    end else begin
      mdl_a <= step(mdl_a);
      mdl_z <= step(mdl_z);
    end
  end

  // Expected waveform: index j is the value after the j-th edge counting the
  // trigger edge as 0; index exp_len is the first idle cycle.
  logic exp_out  [0:127];
  logic exp_busy [0:127];
  int   exp_len;
  int   exp_seg1;

  task automatic build_expect(input logic [15:0] lk, input logic old_lvl,
                              input logic tgt, input int mb, input int mg,
                              input int sc);
    logic [15:0] v;
    int n, len, g, pos;
    int segs[$];
    n = n_of(lk, mb);
    v = lk;
    for (int i = 0; i < 2 * n; i++) begin
      g = int'(v[7:4]);
      len = 1 + ((g > mg - 1) ? mg - 1 : g);
      segs.push_back(len);
      for (int s = 0; s < len; s++) v = step(v);
    end
    pos = 0;
    for (int i = 0; i < segs.size(); i++) begin
      for (int s = 0; s < segs[i]; s++) begin
        exp_out[pos]  = (i % 2 == 0) ? tgt : old_lvl;
        exp_busy[pos] = 1'b1;
        pos++;
      end
    end
    for (int s = 0; s < sc; s++) begin
      exp_out[pos]  = tgt;
      exp_busy[pos] = 1'b1;
      pos++;
    end
    exp_out[pos]  = tgt;
    exp_busy[pos] = 1'b0;
    exp_len  = pos;
    exp_seg1 = (segs.size() > 0) ? segs[0] : 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({out_a, busy_a, out_b, busy_b, out_z, busy_z} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold got a=%b%b b=%b%b z=%b%b want all 0",
               out_a, busy_a, out_b, busy_b, out_z, busy_z);
    end
    rst_n = 1'b1;
    for (int w = 0; w < 40 && n_of(mdl_a, MB) == 0; w++) @(negedge clk);
    lvl_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_a, busy_a} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reset_pre_glitch got out=%b busy=%b want 1 1", out_a, busy_a);
    end
    #2 rst_n = 1'b0;
    lvl_a = 1'b0;
    #1;
    checks++;
    if ({out_a, busy_a} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_async got out=%b busy=%b want 0 0", out_a, busy_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (dut_a.u_lfsr.lfsr !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL reset_lfsr_seed got %h want 1234", dut_a.u_lfsr.lfsr);
    end
    checks++;
    if (dut_z.u_lfsr.lfsr !== 16'hACE1) begin
      errors++;
      $display("[TB] FAIL reset_lfsr_zero_seed got %h want ace1", dut_z.u_lfsr.lfsr);
    end
    @(negedge clk);
    cur_a = 1'b0;
  endtask

  task automatic test_no_bounce();
    int bc, ec;
    logic prev;
    for (int d = 0; d < 2; d++) begin
      lvl_b = ~lvl_b;
      @(negedge clk);
      checks++;
      if ({out_b, busy_b} !== {lvl_b, 1'b1}) begin
        errors++;
        $display("[TB] FAIL nb_latency got out=%b busy=%b want %b 1", out_b, busy_b, lvl_b);
      end
      bc = 0;
      ec = 1;
      prev = out_b;
      for (int c = 0; c < 20 && busy_b === 1'b1; c++) begin
        bc++;
        @(negedge clk);
        if (out_b !== prev) ec++;
        prev = out_b;
      end
      checks++;
      if (bc != SC) begin
        errors++;
        $display("[TB] FAIL nb_busy_len got %0d want %0d", bc, SC);
      end
      checks++;
      if (ec != 1 || out_b !== lvl_b) begin
        errors++;
        $display("[TB] FAIL nb_edges got edges=%0d out=%b want 1 %b", ec, out_b, lvl_b);
      end
    end
  endtask

  task automatic test_passthrough();
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      lvl_a = (i == 9) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({out_a, busy_a} !== {lvl_a, 1'b0}) begin
        errors++;
        $display("[TB] FAIL passthrough i=%0d got out=%b busy=%b want %b 0",
                 i, out_a, busy_a, lvl_a);
      end
    end
    en_a = 1'b1;
    cur_a = 1'b0;
  endtask

  task automatic test_random_bounce();
    logic tgt, prev;
    int edges, gap;
    for (int t = 0; t < 6; t++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if ({out_a, busy_a} !== {cur_a, 1'b0}) begin
          errors++;
          $display("[TB] FAIL rb_idle got out=%b busy=%b want %b 0", out_a, busy_a, cur_a);
        end
      end
      tgt = ~cur_a;
      lvl_a = tgt;
      build_expect(mdl_a, cur_a, tgt, MB, MG, SC);
      edges = 0;
      prev = cur_a;
      for (int j = 0; j <= exp_len; j++) begin
        @(negedge clk);
        checks++;
        if ({out_a, busy_a} !== {exp_out[j], exp_busy[j]}) begin
          errors++;
          $display("[TB] FAIL rb_wave t=%0d j=%0d got out=%b busy=%b want %b %b",
                   t, j, out_a, busy_a, exp_out[j], exp_busy[j]);
        end
        if (out_a !== prev) edges++;
        prev = out_a;
      end
      checks++;
      if (edges % 2 != 1 || edges > 2 * MB + 1 || out_a !== tgt) begin
        errors++;
        $display("[TB] FAIL rb_edges t=%0d got edges=%0d out=%b want odd<=%0d %b",
                 t, edges, out_a, 2 * MB + 1, tgt);
      end
      cur_a = tgt;
    end
  endtask

  task automatic test_back_to_back();
    logic tgt;
    tgt = ~cur_a;
    lvl_a = tgt;
    build_expect(mdl_a, cur_a, tgt, MB, MG, SC);
    for (int j = 0; j <= exp_len; j++) begin
      @(negedge clk);
      checks++;
      if ({out_a, busy_a} !== {exp_out[j], exp_busy[j]}) begin
        errors++;
        $display("[TB] FAIL b2b_first j=%0d got out=%b busy=%b want %b %b",
                 j, out_a, busy_a, exp_out[j], exp_busy[j]);
      end
      if (j == 1) lvl_a = cur_a;
    end
    // level_in already disagrees with the settled level: reverse sequence next edge.
    build_expect(mdl_a, tgt, cur_a, MB, MG, SC);
    for (int j = 0; j <= exp_len; j++) begin
      @(negedge clk);
      checks++;
      if ({out_a, busy_a} !== {exp_out[j], exp_busy[j]}) begin
        errors++;
        $display("[TB] FAIL b2b_reverse j=%0d got out=%b busy=%b want %b %b",
                 j, out_a, busy_a, exp_out[j], exp_busy[j]);
      end
    end
  endtask

  task automatic test_enable_drop();
    if (cur_a !== 1'b0) begin
      en_a = 1'b0;
      lvl_a = 1'b0;
      @(negedge clk);
      en_a = 1'b1;
      cur_a = 1'b0;
    end
    for (int w = 0; w < 60 && n_of(mdl_a, MB) == 0; w++) @(negedge clk);
    checks++;
    if (n_of(mdl_a, MB) == 0) begin
      errors++;
      $display("[TB] FAIL ed_wait_draw got N=0 want N>0 within budget");
      return;
    end
    lvl_a = 1'b1;
    build_expect(mdl_a, 1'b0, 1'b1, MB, MG, SC);
    for (int j = 0; j <= exp_seg1; j++) begin
      @(negedge clk);
      checks++;
      if ({out_a, busy_a} !== {exp_out[j], exp_busy[j]}) begin
        errors++;
        $display("[TB] FAIL ed_glitch j=%0d got out=%b busy=%b want %b %b",
                 j, out_a, busy_a, exp_out[j], exp_busy[j]);
      end
    end
    en_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_a, busy_a} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL ed_abort got out=%b busy=%b want 1 0", out_a, busy_a);
    end
    en_a = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if ({out_a, busy_a} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL ed_quiet c=%0d got out=%b busy=%b want 1 0", c, out_a, busy_a);
      end
    end
    cur_a = 1'b1;
  endtask

  task automatic test_seed_zero();
    logic tgt, deb, e_out, e_busy;
    int dcnt, dedges;
    for (int t = 0; t < 3; t++) begin
      repeat (int'($urandom_range(1, 4))) @(negedge clk);
      tgt = ~cur_z;
      lvl_z = tgt;
      build_expect(mdl_z, cur_z, tgt, MB, MG, SC);
      deb = cur_z;
      dcnt = 0;
      dedges = 0;
      for (int j = 0; j <= exp_len + 12; j++) begin
        @(negedge clk);
        e_out  = (j <= exp_len) ? exp_out[j] : tgt;
        e_busy = (j <= exp_len) ? exp_busy[j] : 1'b0;
        checks++;
        if ({out_z, busy_z} !== {e_out, e_busy}) begin
          errors++;
          $display("[TB] FAIL sz_wave t=%0d j=%0d got out=%b busy=%b want %b %b",
                   t, j, out_z, busy_z, e_out, e_busy);
        end
        checks++;
        if ({out_z, busy_z} !== {out_c, busy_c}) begin
          errors++;
          $display("[TB] FAIL sz_vs_ace1 t=%0d j=%0d got %b%b want %b%b",
                   t, j, out_z, busy_z, out_c, busy_c);
        end
        // Debouncer: flips only after the input disagrees for more than MG samples.
        if (out_z !== deb) begin
          dcnt++;
          if (dcnt > MG) begin
            deb = out_z;
            dcnt = 0;
            dedges++;
          end
        end else begin
          dcnt = 0;
        end
      end
      checks++;
      if (dedges != 1 || deb !== tgt) begin
        errors++;
        $display("[TB] FAIL sz_debounced t=%0d got edges=%0d level=%b want 1 %b",
                 t, dedges, deb, tgt);
      end
      cur_z = tgt;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b1; lvl_a = 1'b0;
    en_b = 1'b1; lvl_b = 1'b0;
    en_z = 1'b1; lvl_z = 1'b0;
    cur_a = 1'b0;
    cur_z = 1'b0;
    test_reset();
    test_no_bounce();
    test_passthrough();
    test_random_bounce();
    test_back_to_back();
    test_enable_drop();
    test_seed_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
